// File: rtl/warp_pkg.sv
// Shared scoreboard constants: execution-unit latencies and countdown width.
package warp_pkg;

    localparam int unsigned LAT_W      = 2;
    localparam int unsigned NUM_REGS   = 32;

    localparam int unsigned LAT_XARITH = 1;
    localparam int unsigned LAT_XLOGIC = 1;
    localparam int unsigned LAT_MUL    = 3;

endpackage

// File: rtl/warp_sb_entry.sv
// One register's in-flight countdown: loads on issue, decrements to zero, flags pending.
module warp_sb_entry
    import warp_pkg::*;
#(
    parameter int unsigned LatW = LAT_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [LatW-1:0] lat_i,
    output logic            pending_o
);

    logic [LatW-1:0] count_q, count_d;

    // A load wins over the decrement; latency 0 is promoted to 1 so a result
    // is never visible to the issue check in its own cycle.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (lat_i == '0) ? LatW'(1) : lat_i;
        end else if (count_q != '0) begin
            count_d = count_q - LatW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pending_o = (count_q != '0);

endmodule

// File: rtl/warp_scoreboard.sv
// Dual-issue in-order register scoreboard with per-register latency countdowns
// and a saturating slot-0 stall counter.
module warp_scoreboard
    import warp_pkg::*;
#(
    parameter int unsigned LAT_W   = warp_pkg::LAT_W,
    parameter int unsigned STALL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid0,
    input  logic [4:0]         i_rs1_0,
    input  logic [4:0]         i_rs2_0,
    input  logic [4:0]         i_rd_0,
    input  logic               i_use_rs1_0,
    input  logic               i_use_rs2_0,
    input  logic               i_wen_0,
    input  logic [LAT_W-1:0]   i_lat_0,
    input  logic               i_valid1,
    input  logic [4:0]         i_rs1_1,
    input  logic [4:0]         i_rs2_1,
    input  logic [4:0]         i_rd_1,
    input  logic               i_use_rs1_1,
    input  logic               i_use_rs2_1,
    input  logic               i_wen_1,
    input  logic [LAT_W-1:0]   i_lat_1,
    input  logic               i_exec_ready,
    output logic               o_issue0,
    output logic               o_issue1,
    output logic [31:0]        o_pending,
    output logic [STALL_W-1:0] o_stall_cycles
);

    logic               haz0, haz1, intra;
    logic [STALL_W-1:0] stall_q, stall_d;

    // x0 has no entry, so its pending bit is tied low and never blocks.
    assign o_pending[0] = 1'b0;

    always_comb begin
        haz0 = (i_use_rs1_0 && i_rs1_0 != 5'd0 && o_pending[i_rs1_0])
            || (i_use_rs2_0 && i_rs2_0 != 5'd0 && o_pending[i_rs2_0])
            || (i_wen_0     && i_rd_0  != 5'd0 && o_pending[i_rd_0]);
        haz1 = (i_use_rs1_1 && i_rs1_1 != 5'd0 && o_pending[i_rs1_1])
            || (i_use_rs2_1 && i_rs2_1 != 5'd0 && o_pending[i_rs2_1])
            || (i_wen_1     && i_rd_1  != 5'd0 && o_pending[i_rd_1]);
        intra = i_wen_0 && i_rd_0 != 5'd0
             && ((i_use_rs1_1 && i_rs1_1 == i_rd_0)
              || (i_use_rs2_1 && i_rs2_1 == i_rd_0)
              || (i_wen_1     && i_rd_1  == i_rd_0));
    end

    // Reset gates issue so nothing launches while tracking is being discarded.
    assign o_issue0 = i_rst_n && i_valid0 && i_exec_ready && !haz0;
    assign o_issue1 = o_issue0 && i_valid1 && !haz1 && !intra;

    for (genvar n = 1; n < NUM_REGS; n++) begin : g_entry
        logic load0, load1;

        assign load0 = o_issue0 && i_wen_0 && (i_rd_0 == 5'(n));
        assign load1 = o_issue1 && i_wen_1 && (i_rd_1 == 5'(n));

        warp_sb_entry #(
            .LatW (LAT_W)
        ) u_entry (
            .clk_i     (i_clk),
            .rst_ni    (i_rst_n),
            .load_i    (load0 || load1),
            .lat_i     (load1 ? i_lat_1 : i_lat_0),
            .pending_o (o_pending[n])
        );
    end

    always_comb begin
        stall_d = stall_q;
        if (i_valid0 && !o_issue0 && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cycles = stall_q;

endmodule

// File: tb/tb_warp_scoreboard.sv
// Directed bench for warp_scoreboard: hand-computed issue, pending and stall-count checks.
module tb_warp_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        valid0, valid1;
    logic [4:0]  rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
    logic        use_rs1_0, use_rs2_0, wen_0, use_rs1_1, use_rs2_1, wen_1;
    logic [1:0]  lat_0, lat_1;
    logic        exec_ready;
    logic        issue0, issue1;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    warp_scoreboard #(
        .LAT_W   (2),
        .STALL_W (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid0       (valid0),
        .i_rs1_0        (rs1_0),
        .i_rs2_0        (rs2_0),
        .i_rd_0         (rd_0),
        .i_use_rs1_0    (use_rs1_0),
        .i_use_rs2_0    (use_rs2_0),
        .i_wen_0        (wen_0),
        .i_lat_0        (lat_0),
        .i_valid1       (valid1),
        .i_rs1_1        (rs1_1),
        .i_rs2_1        (rs2_1),
        .i_rd_1         (rd_1),
        .i_use_rs1_1    (use_rs1_1),
        .i_use_rs2_1    (use_rs2_1),
        .i_wen_1        (wen_1),
        .i_lat_1        (lat_1),
        .i_exec_ready   (exec_ready),
        .o_issue0       (issue0),
        .o_issue1       (issue1),
        .o_pending      (pending),
        .o_stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic slot0(input logic v, input logic u1, input logic [4:0] s1, input logic u2,
                         input logic [4:0] s2, input logic w, input logic [4:0] d,
                         input logic [1:0] l);
        valid0 = v; use_rs1_0 = u1; rs1_0 = s1; use_rs2_0 = u2; rs2_0 = s2;
        wen_0 = w; rd_0 = d; lat_0 = l;
    endtask

    task automatic slot1(input logic v, input logic u1, input logic [4:0] s1, input logic u2,
                         input logic [4:0] s2, input logic w, input logic [4:0] d,
                         input logic [1:0] l);
        valid1 = v; use_rs1_1 = u1; rs1_1 = s1; use_rs2_1 = u2; rs2_1 = s2;
        wen_1 = w; rd_1 = d; lat_1 = l;
    endtask

    task automatic idle();
        slot0(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
        slot1(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        exec_ready = 1'b1;
        idle();

        // Held in reset with a hazard-free slot 0 present.
        slot0(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd2, 2'd1);
        sample();
        check("rst_issue0", 32'(issue0), 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();

        // add x5 (lat 1) in slot 0, independent reader of x6 in slot 1.
        slot0(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 2'd1);
        slot1(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        sample();
        check("dual_issue0", 32'(issue0), 32'd1);
        check("dual_issue1", 32'(issue1), 32'd1);
        step();
        idle();
        sample();
        check("x5_pending", 32'(pending[5]), 32'd1);
        step();
        sample();
        check("x5_cleared", pending, 32'd0);

        // Intra-bundle RAW on x7, then a one-cycle stall on the remaining count.
        step();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 2'd1);
        slot1(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        sample();
        check("raw7_issue0", 32'(issue0), 32'd1);
        check("raw7_issue1", 32'(issue1), 32'd0);
        step();
        idle();
        slot0(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 2'd1);
        sample();
        check("x7_stall", 32'(issue0), 32'd0);
        check("x7_pending", pending, 32'h0000_0080);
        step();
        sample();
        check("x7_issue", 32'(issue0), 32'd1);
        check("x7_stall_cnt", 32'(stall_cycles), 32'd1);

        // Latency-3 producer of x9: reader stalls three cycles.
        step();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd3);
        sample();
        check("x9_produce", 32'(issue0), 32'd1);
        step();
        slot0(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("x9_stall%0d", i), 32'(issue0), 32'd0);
            step();
        end
        sample();
        check("x9_issue", 32'(issue0), 32'd1);
        check("x9_stall_cnt", 32'(stall_cycles), 32'd4);

        // Writes to x0 never create tracking.
        step();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'd3);
        slot1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'd3);
        sample();
        check("x0_issue0", 32'(issue0), 32'd1);
        check("x0_issue1", 32'(issue1), 32'd1);
        step();
        idle();
        slot0(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 2'd3);
        sample();
        check("x0_read", 32'(issue0), 32'd1);
        check("x0_pending", pending, 32'd0);

        // Execution back-pressure: x3 still counts down, stalls accumulate.
        step();
        idle();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'd3);
        step();
        exec_ready = 1'b0;
        slot0(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        slot1(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        sample();
        check("bp_issue0", 32'(issue0), 32'd0);
        check("bp_issue1", 32'(issue1), 32'd0);
        check("bp_pend3", pending, 32'h0000_0008);
        step();
        sample();
        check("bp_stall1", 32'(stall_cycles), 32'd5);
        check("bp_pend3b", pending, 32'h0000_0008);
        step();
        step();
        sample();
        check("bp_stall3", 32'(stall_cycles), 32'd7);
        check("bp_drained", pending, 32'd0);

        // Reset while x12 is mid-countdown.
        step();
        exec_ready = 1'b1;
        idle();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 2'd3);
        step();
        idle();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_pending", pending, 32'd0);
        check("mid_rst_stall", 32'(stall_cycles), 32'd0);
        slot0(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        #1;
        check("mid_rst_issue0", 32'(issue0), 32'd0);
        step();
        rst_n = 1'b1;
        sample();
        check("post_rst_issue", 32'(issue0), 32'd1);
        step();
        sample();
        check("post_rst_stall", 32'(stall_cycles), 32'd0);

        // Saturation of the stall counter.
        exec_ready = 1'b0;
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        idle();
        slot0(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd1);
        repeat (16'hFFFE) @(posedge clk);
        sample();
        check("sat_fffe", 32'(stall_cycles), 32'h0000_FFFE);
        repeat (3) @(posedge clk);
        sample();
        check("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
